seq_alu: RTL and testbench

Parametrised multi-cycle ALU replacing the purely combinational datapath ALU. It performs single-cycle logic, arithmetic, shift and rotate operations, plus iterative signed multiply (radix-2 Booth) and signed divide, under a start/busy/done handshake. Results go to the Z register pair as `zlow`/`zhigh`. It sits between the Y register (operand `a`), the bus (operand `b`) and the Z register load logic, so the control unit stalls on `busy` instead of assuming a single-cycle multiply or divide.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_divider.sv | 76 +++++++
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes and control states.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_SHRA = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Signed divide core: restoring divider on magnitudes, with
// the sign correction applied when the FIX cycle latches results.
module seq_divider
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] bmag;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  // Magnitude of the most-negative value is still exact as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = shifted - {1'b0, bmag};
    if (trial[WIDTH]) begin
      r_nx = shifted[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b0};
    end else begin
      r_nx = trial[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt   <= '0;
      r     <= '0;
      q     <= '0;
      bmag  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      r     <= '0;
      q     <= mag(a);
      bmag  <= mag(b);
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (step) begin
      cnt <= cnt + CW'(1);
      r   <= r_nx;
      q   <= q_nx;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign quo  = neg_q ? -q : q;
  assign rem  = neg_r ? -r : r;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops, Booth multiply and
// signed divide behind a start/busy/done handshake.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             qm1;
  logic [WIDTH-1:0] mcand;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic             qm1_nx;

  logic [SHW-1:0]   sh;
  logic [SHW:0]     inv;
  logic [WIDTH-1:0] res;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             b_zero;

  logic             div_load;
  logic             div_step;
  logic             div_last;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign busy     = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign accept   = start && !busy;
  assign is_mul   = (op == OP_MUL);
  assign is_div   = (op == OP_DIV);
  assign b_zero   = (b == '0);
  assign div_load = accept && is_div && !b_zero;
  assign div_step = (state == S_DIV);

  assign sh  = b[SHW-1:0];
  assign inv = (SHW+1)'(WIDTH) - {1'b0, sh};

  // A zero amount gives inv == WIDTH, so the wrap term shifts out fully.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SHR:  res = a >> sh;
      OP_SHL:  res = a << sh;
      OP_ROR:  res = (a >> sh) | (a << inv);
      OP_ROL:  res = (a << sh) | (a >> inv);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SHRA: res = WIDTH'($signed(a) >>> sh);
      OP_NEG:  res = -a;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end

  // Extra accumulator bit keeps -(most negative) from overflowing.
  assign m_ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    case ({mq[0], qm1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    {acc_nx, mq_nx, qm1_nx} = {acc_sum[WIDTH], acc_sum, mq};
  end

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clock(clock),
    .clear(clear),
    .load (div_load),
    .step (div_step),
    .a    (a),
    .b    (b),
    .last (div_last),
    .quo  (div_quo),
    .rem  (div_rem)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      qm1      <= 1'b0;
      mcand    <= '0;
      zlow     <= '0;
      zhigh    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            div_zero <= is_div && b_zero;
            if (is_mul) begin
              acc   <= '0;
              mq    <= a;
              qm1   <= 1'b0;
              mcand <= b;
              cnt   <= '0;
              state <= S_MUL;
            end else if (is_div && !b_zero) begin
              state <= S_DIV;
            end else if (is_div) begin
              zlow  <= '1;
              zhigh <= a;
              state <= S_DONE;
            end else begin
              zlow  <= res;
              zhigh <= {WIDTH{res[WIDTH-1]}};
              state <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          qm1 <= qm1_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            zhigh <= acc_nx[WIDTH-1:0];
            zlow  <= mq_nx;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          if (div_last)
            state <= S_FIX;
        end
        S_FIX: begin
          zlow  <= div_quo;
          zhigh <= div_rem;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at start,
// checked when done pulses.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] zlow;
  logic [W-1:0] zhigh;
  logic         div_zero;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .zlow    (zlow),
    .zhigh   (zhigh),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi,
                              input logic dz, input int lat);
    exp_t e;
    e.lo = lo; e.hi = hi; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    int s;
    longint p, sx, sy, q, r;
    logic [63:0] pv;
    s = int'(y[4:0]);
    e = mk('0, '0, 1'b0, 1);
    case (o)
      OP_ADD:  e.lo = x + y;
      OP_SUB:  e.lo = x - y;
      OP_SHR:  e.lo = x >> s;
      OP_SHL:  e.lo = x << s;
      OP_ROR:  e.lo = (x >> s) | (x << (W - s));
      OP_ROL:  e.lo = (x << s) | (x >> (W - s));
      OP_AND:  e.lo = x & y;
      OP_OR:   e.lo = x | y;
      OP_SHRA: e.lo = W'($signed(x) >>> s);
      OP_NEG:  e.lo = -x;
      OP_NOT:  e.lo = ~x;
      default: e.lo = '0;
    endcase
    e.hi = {W{e.lo[W-1]}};
    if (o == OP_MUL) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = sx * sy;
      pv = 64'(p);
      e  = mk(pv[31:0], pv[63:32], 1'b0, W + 1);
    end else if (o == OP_DIV) begin
      if (y == '0) begin
        e = mk('1, x, 1'b1, 1);
      end else begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        e  = mk(W'(q), W'(r), 1'b0, W + 2);
      end
    end
    return e;
  endfunction

  // poke > 0 pulses a stray add start that many cycles after E0.
  task automatic run(input logic [4:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input exp_t e, input int poke);
    exp_t got_e;
    int lat;
    logic seen_busy;
    sb.push_back(e);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 1;
    seen_busy = 1'b0;
    while (!done && lat < 200) begin
      seen_busy = seen_busy | busy;
      if (lat == poke) begin
        @(negedge clock);
        op = OP_ADD; a = 1; b = 1; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("poke_busy", busy, 1);
      end else begin
        @(posedge clock);
        #1;
      end
      lat++;
    end
    got_e = sb.pop_front();
    if (!done) begin
      check("timeout", lat, got_e.lat);
    end else begin
      check("zlow", zlow, got_e.lo);
      check("zhigh", zhigh, got_e.hi);
      check("div_zero", div_zero, got_e.dz);
      check("latency", lat, got_e.lat);
      check("busy_seen", seen_busy, got_e.lat > 1);
      check("busy_at_done", busy, 0);
    end
  endtask

  logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                           OP_AND, OP_OR, OP_SHRA, OP_MUL, OP_DIV, OP_NEG,
                           OP_NOT};

  initial begin
    logic [4:0] o;
    logic [W-1:0] x, y;

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zlow", zlow, 0);
    check("rst_zhigh", zhigh, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clock);
    clear = 1'b0;

    run(OP_ADD, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 1), 0);
    run(OP_MUL, 32'hFFFF_FFFD, 32'h7, mk(32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 33), 0);
    run(OP_MUL, 32'h8000_0000, 32'h8000_0000, mk(32'h0, 32'h4000_0000, 0, 33), 0);
    run(OP_DIV, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 34), 0);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'h0, 0, 34), 0);
    run(OP_DIV, 32'h5, 32'h0, mk(32'hFFFF_FFFF, 32'h5, 1, 1), 0);
    run(OP_ADD, 32'h1, 32'h2, mk(32'h3, 32'h0, 0, 1), 0);
    run(OP_ROR, 32'h1, 32'h1, mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 1), 0);
    run(OP_SHRA, 32'h8000_0000, 32'h4, mk(32'hF800_0000, 32'hFFFF_FFFF, 0, 1), 0);
    run(OP_SHL, 32'h1234, 32'd32, mk(32'h1234, 32'h0, 0, 1), 0);
    run(5'b11111, 32'h5, 32'h5, mk(32'h0, 32'h0, 0, 1), 0);
    run(OP_MUL, 32'h0001_2345, 32'hFFFF_0F0F,
        model(OP_MUL, 32'h0001_2345, 32'hFFFF_0F0F), 5);

    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(0, 12)];
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) y = y & 32'h1F;
      run(o, x, y, model(o, x, y), 0);
    end

    run(OP_NOT, 32'h0, 32'h0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1), 0);

    @(negedge clock);
    op = OP_MUL; a = 32'h0000_0003; b = 32'h0000_0005; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    op = OP_ADD; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("ignored_start", busy, 1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_zlow", zlow, 0);
    check("clr_zhigh", zhigh, 0);
    @(negedge clock);
    clear = 1'b0;

    run(OP_ADD, 32'h10, 32'h20, mk(32'h30, 32'h0, 0, 1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
